// File: rtl/tea_pkg.sv
// Shared TEA definitions: round constant, default round count, block/key
// types, sequencer state encoding and the single round-pair function.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA  = 32'h9E3779B9;
    localparam int          TEA_ROUNDS = 32;

    typedef logic [63:0]  block_t;
    typedef logic [127:0] key_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GEN     = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_OUT     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // One TEA round pair; sum is the already-advanced running sum.
    // v1 is updated with the new v0, as in the reference algorithm.
    function automatic block_t tea_round(input block_t v, input key_t k, input logic [31:0] sum);
        logic [31:0] v0;
        logic [31:0] v1;
        v0 = v[63:32];
        v1 = v[31:0];
        v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
        v1 = v1 + (((v0 << 4) + k[63:32])  ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
        return {v0, v1};
    endfunction

endpackage

// File: rtl/tea_core_iter.sv
// Iterative TEA encryptor: loads the block on start, then performs one
// round pair per clock. done pulses for one cycle once all ROUNDS are
// complete; result stays valid until the next start.
module tea_core_iter
    import tea_pkg::*;
#(
    parameter int ROUNDS = TEA_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  block,
    input  logic [127:0] key,
    output logic         done,
    output logic [63:0]  result
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    block_t           v_reg;
    logic [31:0]      sum_reg;
    logic [31:0]      sum_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             run_reg;
    logic             done_reg;

    assign sum_next = sum_reg + TEA_DELTA;
    assign done     = done_reg;
    assign result   = v_reg;

    // Round engine: start restarts from scratch even if a run is in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_reg    <= '0;
            sum_reg  <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                v_reg   <= block;
                sum_reg <= '0;
                cnt_reg <= '0;
                run_reg <= 1'b1;
            end else if (run_reg) begin
                v_reg   <= tea_round(v_reg, key, sum_next);
                sum_reg <= sum_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(ROUNDS - 1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tea_ctr_sched.sv
// TEA-CTR message sequencer. Takes a descriptor (key, nonce, start counter,
// block count) and streams that many 64-bit blocks, XORing each with the
// TEA encryption of {nonce, ctr}. Blocks are processed strictly one at a time.
// Optional build macro CTR_WRAP_CHECK_EN: reject descriptors whose counter
// range would run past 2^32 (err pulse, no message); otherwise the counter
// silently wraps and err stays 0.
module tea_ctr_sched
    import tea_pkg::*;
#(
    parameter int ROUNDS = TEA_ROUNDS,
    parameter int NBLK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [127:0]      cfg_key,
    input  logic [31:0]       cfg_nonce,
    input  logic [31:0]       cfg_ctr0,
    input  logic [NBLK_W-1:0] cfg_nblk,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_reg;
    state_t            state_next;
    key_t              key_reg;
    logic [31:0]       nonce_reg;
    logic [31:0]       ctr_reg;
    logic [NBLK_W-1:0] rem_reg;
    block_t            ks_reg;
    logic [63:0]       out_data_reg;
    logic              out_valid_reg;
    logic              done_reg;
    logic              err_reg;

    logic              cfg_hs;
    logic              in_hs;
    logic              out_hs;
    logic              cfg_bad;
    logic              core_start;
    block_t            core_block;
    logic              core_done;
    block_t            core_result;

    // Handshakes are derived from the state directly to keep the ready
    // outputs free of combinational loops.
    assign cfg_hs = cfg_valid && (state_reg == ST_IDLE);
    assign in_hs  = in_valid  && (state_reg == ST_WAIT_IN);
    assign out_hs = out_ready && out_valid_reg;

`ifdef CTR_WRAP_CHECK_EN
    logic [32:0] ctr_end;
    assign ctr_end = {1'b0, cfg_ctr0} + 33'(cfg_nblk);
    assign cfg_bad = (ctr_end > 33'h1_0000_0000);
`else
    assign cfg_bad = 1'b0;
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;
    assign err       = err_reg;

    tea_core_iter #(
        .ROUNDS (ROUNDS)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .block  (core_block),
        .key    (key_reg),
        .done   (core_done),
        .result (core_result)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cfg_hs && !cfg_bad) state_next = (cfg_nblk == '0) ? ST_DONE : ST_GEN;
            ST_GEN:     if (core_done) state_next = ST_WAIT_IN;
            ST_WAIT_IN: if (in_hs) state_next = ST_OUT;
            ST_OUT:     if (out_hs) state_next = (rem_reg == NBLK_W'(1)) ? ST_DONE : ST_GEN;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs. The core is launched on the very edge that
    // enters GEN, using the counter value that edge is about to latch, so the
    // keystream lands ROUNDS+1 cycles later without an extra idle cycle.
    always_comb begin
        cfg_ready  = (state_reg == ST_IDLE);
        in_ready   = (state_reg == ST_WAIT_IN);
        busy       = (state_reg != ST_IDLE);
        core_start = 1'b0;
        core_block = {nonce_reg, ctr_reg + 32'd1};
        if ((state_reg == ST_IDLE) && cfg_hs && !cfg_bad && (cfg_nblk != '0)) begin
            core_start = 1'b1;
            core_block = {cfg_nonce, cfg_ctr0};
        end
        if ((state_reg == ST_OUT) && out_hs && (rem_reg != NBLK_W'(1))) begin
            core_start = 1'b1;
        end
    end

    // Descriptor, counter, keystream and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            key_reg       <= '0;
            nonce_reg     <= '0;
            ctr_reg       <= '0;
            rem_reg       <= '0;
            ks_reg        <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= (state_reg == ST_DONE);
            err_reg  <= cfg_hs && cfg_bad;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_hs && !cfg_bad) begin
                        key_reg   <= cfg_key;
                        nonce_reg <= cfg_nonce;
                        ctr_reg   <= cfg_ctr0;
                        rem_reg   <= cfg_nblk;
                    end
                end
                ST_GEN: begin
                    if (core_done) ks_reg <= core_result;
                end
                ST_WAIT_IN: begin
                    if (in_hs) begin
                        out_data_reg  <= in_data ^ ks_reg;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_hs) begin
                        out_valid_reg <= 1'b0;
                        ctr_reg       <= ctr_reg + 32'd1;
                        rem_reg       <= rem_reg - NBLK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_ctr_sched.sv
// Scoreboard bench for tea_ctr_sched: stimulus pushes expected output blocks,
// an independent monitor pops and compares on every output handshake.
module tb_tea_ctr_sched;

    localparam int ROUNDS = 32;
    localparam int NBLK_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [127:0]      cfg_key;
    logic [31:0]       cfg_nonce;
    logic [31:0]       cfg_ctr0;
    logic [NBLK_W-1:0] cfg_nblk;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic [63:0] blk_in[8];
    logic [63:0] blk_exp[8];

    tea_ctr_sched #(
        .ROUNDS (ROUNDS),
        .NBLK_W (NBLK_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_key   (cfg_key),
        .cfg_nonce (cfg_nonce),
        .cfg_ctr0  (cfg_ctr0),
        .cfg_nblk  (cfg_nblk),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Reference TEA encryption written straight from the algorithm.
    function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] b);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        y = b[63:32]; z = b[31:0]; s = 32'h0;
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        for (int r = 0; r < ROUNDS; r++) begin
            s = s + 32'h9E3779B9;
            y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
            z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
        end
        return {y, z};
    endfunction

    // Monitor: one line per output transaction, plus hold/exclusivity checks.
    initial begin : monitor
        logic [63:0] held;
        logic        hold_valid;
        hold_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                hold_valid = 1'b0;
            end else if (out_valid) begin
                check("in_ready_while_out_valid", 64'(in_ready), 64'd0);
                if (hold_valid) check("out_data_hold", out_data, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h required no output", out_data);
                    end else begin
                        $display("[TB] out block %h (cycle %0d)", out_data, cyc);
                        check("out_data", out_data, exp_q.pop_front());
                    end
                    got_q.push_back(out_data);
                    hold_valid = 1'b0;
                end else begin
                    held = out_data;
                    hold_valid = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"},  out_data,       64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_done"},      64'(done),      64'd0);
        check({tag, "_err"},       64'(err),       64'd0);
    endtask

    // Called at a negedge; returns at the negedge right after the handshake
    // edge, with hs set to that edge's number.
    task automatic send_cfg(input logic [127:0] key, input logic [31:0] nonce,
                            input logic [31:0] ctr0, input int nblk, output int hs);
        int t;
        t = 0;
        cfg_key = key; cfg_nonce = nonce; cfg_ctr0 = ctr0; cfg_nblk = NBLK_W'(nblk);
        cfg_valid = 1'b1;
        while (!cfg_ready && t < 200) begin @(negedge clk); t++; end
        check("cfg_accept", 64'(cfg_ready), 64'd1);
        hs = cyc + 1;
        $display("[TB] cfg nonce=%h ctr0=%h nblk=%0d (edge %0d)", nonce, ctr0, nblk, hs);
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_key = {4{32'h5A5A_C3C3}}; cfg_nonce = 32'hDEAD_BEEF; cfg_ctr0 = 32'h1234_5678; cfg_nblk = '1;
    endtask

    task automatic feed(input logic [63:0] data, input logic [63:0] expv);
        int t;
        t = 0;
        in_data = data;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin @(negedge clk); t++; end
        check("in_accept", 64'(in_ready), 64'd1);
        if (in_ready) exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 64'hA0A0_B1B1_C2C2_D3D3;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 400) begin @(negedge clk); t++; end
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_msg(input logic [127:0] key, input logic [31:0] nonce,
                           input logic [31:0] ctr0, input int nblk, input bit use_model);
        int hs;
        logic [63:0] e;
        send_cfg(key, nonce, ctr0, nblk, hs);
        for (int i = 0; i < nblk; i++) begin
            e = use_model ? (blk_in[i] ^ tea_ref(key, {nonce, ctr0 + 32'(i)})) : blk_exp[i];
            feed(blk_in[i], e);
        end
        wait_done();
    endtask

    initial begin : stim
        int hs;
        int t;
        int base;
        logic [127:0] k2;
        logic [63:0]  orig[4];

        cfg_valid = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_ctr0 = '0; cfg_nblk = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // 1) all-zero known vector, plus first in_ready latency
        send_cfg('0, 32'h0, 32'h0, 1, hs);
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        check("in_ready_latency", 64'(cyc - hs + 1), 64'(ROUNDS + 2));
        feed(64'h0, 64'h41EA3A0A94BAA940);
        wait_done();

        // 2) four blocks, then the outputs fed back under the same descriptor
        k2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        orig[0] = 64'h0011223344556677; orig[1] = 64'h8899AABBCCDDEEFF;
        orig[2] = 64'hDEADBEEFCAFEF00D; orig[3] = 64'h0F0F0F0FF0F0F0F0;
        for (int i = 0; i < 4; i++) blk_in[i] = orig[i];
        base = got_q.size();
        run_msg(k2, 32'hA5A5_0001, 32'h0000_1000, 4, 1'b1);
        check("pass1_count", 64'(got_q.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            blk_in[i]  = got_q[base + i];
            blk_exp[i] = orig[i];
        end
        run_msg(k2, 32'hA5A5_0001, 32'h0000_1000, 4, 1'b0);

        // 3) downstream stall of 10 cycles on the second block
        for (int i = 0; i < 3; i++) blk_in[i] = 64'h1111_0000_0000_0000 * 64'(i + 1) + 64'h77;
        base = got_q.size();
        fork
            run_msg(128'hFFEEDDCC_BBAA9988_77665544_33221100, 32'h0BAD_F00D, 32'h7FFF_FFFE, 3, 1'b1);
            begin : stall
                int ts;
                ts = 0;
                while (got_q.size() < base + 1 && ts < 500) begin @(negedge clk); ts++; end
                while (!out_valid && ts < 1000) begin @(negedge clk); ts++; end
                out_ready = 1'b0;
                repeat (10) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("stall_block_count", 64'(got_q.size() - base), 64'd3);

        // 4) empty message
        send_cfg(128'h1, 32'h1, 32'h1, 0, hs);
        for (int n = 0; n < 4; n++) begin
            check("nblk0_done", 64'(done), 64'((cyc - hs + 1) == 2));
            check("nblk0_in_ready", 64'(in_ready), 64'd0);
            check("nblk0_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // 5) counter range crossing 2^32
`ifdef CTR_WRAP_CHECK_EN
        send_cfg(128'h2, 32'hCAFE_0005, 32'hFFFF_FFFF, 2, hs);
        check("wrap_err", 64'(err), 64'd1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("wrap_err_width", 64'(err), 64'd0);
            check("wrap_idle", 64'(busy), 64'd0);
            check("wrap_no_done", 64'(done), 64'd0);
            check("wrap_no_out", 64'(out_valid), 64'd0);
        end
`else
        blk_in[0] = 64'h0123_4567_89AB_CDEF;
        blk_in[1] = 64'hFEDC_BA98_7654_3210;
        run_msg(128'h2, 32'hCAFE_0005, 32'hFFFF_FFFF, 2, 1'b1);
        check("wrap_no_err", 64'(err), 64'd0);
`endif

        // 6) reset while generating block 2, then a clean message
        k2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
        base = got_q.size();
        send_cfg(k2, 32'h3333_4444, 32'h10, 3, hs);
        feed(64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888 ^ tea_ref(k2, {32'h3333_4444, 32'h10}));
        t = 0;
        while (got_q.size() < base + 1 && t < 200) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        check("gen_busy", 64'(busy), 64'd1);
        check("gen_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b1;
        exp_q.delete();
        blk_in[0] = 64'h9999_AAAA_BBBB_CCCC;
        blk_in[1] = 64'hDDDD_EEEE_FFFF_0000;
        run_msg(k2, 32'h3333_4444, 32'h20, 2, 1'b1);

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
